// File: rtl/conv_pass_scheduler_if.sv
// Handshake bundle between the convolution pass scheduler, the layer-control
// registers, the activation window loader and the MAC array.
interface conv_pass_scheduler_if #(
    parameter int unsigned DIM_W = 12
);
    logic             start;
    logic [DIM_W-1:0] out_width;
    logic [DIM_W-1:0] out_height;
    logic [DIM_W-1:0] channel;
    logic             busy;
    logic             pass_done;
    logic             load_start;
    logic             load_done;
    logic             mac_start;
    logic             mac_first;
    logic             mac_done;
    logic             wr_valid;
    logic [DIM_W-1:0] out_x;
    logic [DIM_W-1:0] out_y;
    logic [DIM_W-1:0] ch_idx;

    modport master (
        input  start, out_width, out_height, channel, load_done, mac_done,
        output busy, pass_done, load_start, mac_start, mac_first, wr_valid,
               out_x, out_y, ch_idx
    );

    modport slave (
        output start, out_width, out_height, channel, load_done, mac_done,
        input  busy, pass_done, load_start, mac_start, mac_first, wr_valid,
               out_x, out_y, ch_idx
    );
endinterface

// File: rtl/conv_pass_scheduler.sv
// Sequences one convolution pass: output pixels row-major, channels innermost,
// one window load and one MAC per channel, a write strobe per finished pixel.
module conv_pass_scheduler #(
    parameter int unsigned DIM_W = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    conv_pass_scheduler_if.master         bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD_REQ,
        LOAD_WAIT,
        MAC_REQ,
        MAC_WAIT,
        WRITE,
        FINISH
    } state_t;

    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

    state_t           state, state_n;
    logic [DIM_W-1:0] width_q, height_q, chan_q;
    logic [DIM_W-1:0] width_n, height_n, chan_n;
    logic [DIM_W-1:0] x_q, y_q, ch_q;
    logic [DIM_W-1:0] x_n, y_n, ch_n;

    logic busy_q, pass_done_q, load_start_q, mac_start_q, mac_first_q, wr_valid_q;
    logic busy_n, pass_done_n, load_start_n, mac_start_n, mac_first_n, wr_valid_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            width_q      <= '0;
            height_q     <= '0;
            chan_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            ch_q         <= '0;
            busy_q       <= 1'b0;
            pass_done_q  <= 1'b0;
            load_start_q <= 1'b0;
            mac_start_q  <= 1'b0;
            mac_first_q  <= 1'b0;
            wr_valid_q   <= 1'b0;
        end else begin
            state        <= state_n;
            width_q      <= width_n;
            height_q     <= height_n;
            chan_q       <= chan_n;
            x_q          <= x_n;
            y_q          <= y_n;
            ch_q         <= ch_n;
            busy_q       <= busy_n;
            pass_done_q  <= pass_done_n;
            load_start_q <= load_start_n;
            mac_start_q  <= mac_start_n;
            mac_first_q  <= mac_first_n;
            wr_valid_q   <= wr_valid_n;
        end
    end

    always_comb begin
        state_n  = state;
        width_n  = width_q;
        height_n = height_q;
        chan_n   = chan_q;
        x_n      = x_q;
        y_n      = y_q;
        ch_n     = ch_q;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    width_n  = bus.out_width;
                    height_n = bus.out_height;
                    chan_n   = bus.channel;
                    x_n      = '0;
                    y_n      = '0;
                    ch_n     = '0;
                    if (bus.out_width == '0 || bus.out_height == '0 || bus.channel == '0)
                        state_n = FINISH;
                    else
                        state_n = LOAD_REQ;
                end
            end
            LOAD_REQ:  state_n = LOAD_WAIT;
            LOAD_WAIT: if (bus.load_done) state_n = MAC_REQ;
            MAC_REQ:   state_n = MAC_WAIT;
            MAC_WAIT: begin
                if (bus.mac_done) begin
                    if (ch_q < chan_q - ONE) begin
                        ch_n    = ch_q + ONE;
                        state_n = LOAD_REQ;
                    end else begin
                        state_n = WRITE;
                    end
                end
            end
            WRITE: begin
                ch_n = '0;
                if (x_q == width_q - ONE) begin
                    x_n = '0;
                    y_n = y_q + ONE;
                    state_n = (y_q == height_q - ONE) ? FINISH : LOAD_REQ;
                end else begin
                    x_n     = x_q + ONE;
                    state_n = LOAD_REQ;
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Strobes are decoded from the next state so they are registered and
        // coincide exactly with the cycle spent in the corresponding state.
        busy_n       = (state_n != IDLE);
        pass_done_n  = (state_n == FINISH);
        load_start_n = (state_n == LOAD_REQ);
        mac_start_n  = (state_n == MAC_REQ);
        mac_first_n  = (state_n == MAC_REQ) && (ch_n == '0);
        wr_valid_n   = (state_n == WRITE);
    end

    assign bus.busy       = busy_q;
    assign bus.pass_done  = pass_done_q;
    assign bus.load_start = load_start_q;
    assign bus.mac_start  = mac_start_q;
    assign bus.mac_first  = mac_first_q;
    assign bus.wr_valid   = wr_valid_q;
    assign bus.out_x      = x_q;
    assign bus.out_y      = y_q;
    assign bus.ch_idx     = ch_q;
endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Directed bench for conv_pass_scheduler with simple loader and MAC responders.
module tb_conv_pass_scheduler;
    localparam int unsigned DIM_W = 12;
    localparam int LOAD_LAT = 4;
    localparam int MAC_LAT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_pass_scheduler_if #(.DIM_W(DIM_W)) bus ();

    conv_pass_scheduler #(.DIM_W(DIM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic load_model = 1'b0, load_force = 1'b0;
    logic mac_model  = 1'b0, stray_mac  = 1'b0, stray_en = 1'b0;
    int   ld_cnt = 0, mac_cnt = 0;

    assign bus.load_done = load_model | load_force;
    assign bus.mac_done  = mac_model | stray_mac;

    // Loader: clears done when it accepts load_start, raises it LOAD_LAT edges later.
    always @(posedge clk) begin
        if (rst) begin
            load_model <= 1'b0;
            ld_cnt     <= 0;
        end else if (bus.load_start) begin
            load_model <= 1'b0;
            ld_cnt     <= LOAD_LAT;
        end else if (ld_cnt != 0) begin
            ld_cnt <= ld_cnt - 1;
            if (ld_cnt == 1) load_model <= 1'b1;
        end
    end

    always @(posedge clk) begin
        mac_model <= 1'b0;
        if (rst) begin
            mac_cnt <= 0;
        end else if (bus.mac_start) begin
            mac_cnt <= MAC_LAT;
        end else if (mac_cnt != 0) begin
            mac_cnt <= mac_cnt - 1;
            if (mac_cnt == 1) mac_model <= 1'b1;
        end
    end

    // Spurious mac_done pulse one cycle after each load request (scheduler in LOAD_WAIT).
    always @(posedge clk) stray_mac <= stray_en && bus.load_start && !rst;

    int n_busy = 0, n_load = 0, n_mac = 0, n_first = 0, n_first_bad = 0;
    int n_wr = 0, n_wr_bad = 0, n_done = 0, cur_mac = 0, cur_wr = 0;
    int exp_w = 1, exp_ch = 1;

    always @(negedge clk) begin
        if (!bus.busy) begin
            cur_mac = 0;
            cur_wr  = 0;
        end
        if (bus.busy) n_busy++;
        if (bus.load_start) n_load++;
        if (bus.mac_start) begin
            if (bus.mac_first != ((cur_mac % exp_ch) == 0)) n_first_bad++;
            if (bus.mac_first) n_first++;
            cur_mac++;
            n_mac++;
        end
        if (bus.wr_valid) begin
            if (int'(bus.out_x) != cur_wr % exp_w || int'(bus.out_y) != cur_wr / exp_w)
                n_wr_bad++;
            cur_wr++;
            n_wr++;
        end
        if (bus.pass_done) n_done++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       int'(bus.busy), 0);
        check({tag, "_pass_done"},  int'(bus.pass_done), 0);
        check({tag, "_load_start"}, int'(bus.load_start), 0);
        check({tag, "_mac_start"},  int'(bus.mac_start), 0);
        check({tag, "_mac_first"},  int'(bus.mac_first), 0);
        check({tag, "_wr_valid"},   int'(bus.wr_valid), 0);
        check({tag, "_out_x"},      int'(bus.out_x), 0);
        check({tag, "_out_y"},      int'(bus.out_y), 0);
        check({tag, "_ch_idx"},     int'(bus.ch_idx), 0);
    endtask

    // One full pass; disturb re-pulses start with a new width mid-pass.
    task automatic run_pass(input string tag, input int w, input int h, input int c,
                            input int e_load, input int e_first, input int e_wr,
                            input int e_busy, input bit disturb);
        int s_busy, s_load, s_mac, s_first, s_wr, s_done, s_fbad, s_wbad;
        bit seen;
        s_busy = n_busy; s_load = n_load; s_mac = n_mac; s_first = n_first;
        s_wr = n_wr; s_done = n_done; s_fbad = n_first_bad; s_wbad = n_wr_bad;
        exp_w  = (w == 0) ? 1 : w;
        exp_ch = (c == 0) ? 1 : c;
        bus.out_width  = DIM_W'(w);
        bus.out_height = DIM_W'(h);
        bus.channel    = DIM_W'(c);
        bus.start      = 1'b1;
        load_force     = 1'b0;
        tick();
        bus.start = 1'b0;
        check({tag, "_first_load"}, int'(bus.load_start), (e_load > 0) ? 1 : 0);
        seen = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            if (bus.pass_done) begin
                seen = 1'b1;
                break;
            end
            if (disturb && i == 20) begin
                bus.out_width = DIM_W'(5);
                bus.start     = 1'b1;
            end
            if (disturb && i == 21) bus.start = 1'b0;
            tick();
        end
        check({tag, "_pass_done_seen"}, int'(seen), 1);
        check({tag, "_busy_at_done"}, int'(bus.busy), 1);
        tick();
        check({tag, "_busy_after"}, int'(bus.busy), 0);
        check({tag, "_done_pulse"}, int'(bus.pass_done), 0);
        check({tag, "_loads"}, n_load - s_load, e_load);
        check({tag, "_macs"}, n_mac - s_mac, e_load);
        check({tag, "_mac_firsts"}, n_first - s_first, e_first);
        check({tag, "_mac_first_order"}, n_first_bad - s_fbad, 0);
        check({tag, "_writes"}, n_wr - s_wr, e_wr);
        check({tag, "_write_coords"}, n_wr_bad - s_wbad, 0);
        check({tag, "_pass_dones"}, n_done - s_done, 1);
        check({tag, "_busy_cycles"}, n_busy - s_busy, e_busy);
    endtask

    initial begin
        int s_done;
        bus.start      = 1'b0;
        bus.out_width  = '0;
        bus.out_height = '0;
        bus.channel    = '0;
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // 2x2 pixels, 3 channels: 10 cycles per channel, 31 per pixel, +1 FINISH.
        run_pass("basic", 2, 2, 3, 12, 4, 4, 125, 1'b0);

        run_pass("zero_ch", 3, 3, 0, 0, 0, 0, 1, 1'b0);
        run_pass("zero_w", 0, 2, 2, 0, 0, 0, 1, 1'b0);

        load_force = 1'b1;
        repeat (3) tick();
        check("idle_with_load_done", int'(bus.busy), 0);
        stray_en = 1'b1;
        run_pass("stale", 2, 2, 3, 12, 4, 4, 125, 1'b0);
        stray_en = 1'b0;

        run_pass("busy_start", 2, 2, 3, 12, 4, 4, 125, 1'b1);

        // Abort mid-pass with a 3-cycle reset.
        s_done = n_done;
        exp_w = 2; exp_ch = 3;
        bus.out_width = DIM_W'(2); bus.out_height = DIM_W'(2); bus.channel = DIM_W'(3);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (30) tick();
        check("midpass_busy", int'(bus.busy), 1);
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("midpass_reset");
        rst = 1'b0;
        repeat (5) tick();
        check("after_reset_idle", int'(bus.busy), 0);
        check("reset_no_pass_done", n_done - s_done, 0);

        // Max-width single row: 11 cycles per pixel, row wrap on the final write.
        run_pass("wrap_max", 4095, 1, 1, 4095, 4095, 4095, 4095 * 11 + 1, 1'b0);
        check("wrap_out_x", int'(bus.out_x), 0);
        check("wrap_out_y", int'(bus.out_y), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_pass_scheduler.md
# conv_pass_scheduler

Sequences one convolution pass over the 3×3 activation window loader and the MAC array. Walks output positions row-major and channels innermost. For each step it handshakes a window load, then a MAC operation, and emits a write strobe with coordinates once a pixel's last channel has been accumulated. It sits between the layer-control registers and the activation-loader / MAC datapath.

## Interface
- DIM_W, 12, width of dimension inputs and all position counters
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a pass; sampled only in IDLE
- out_width  in  DIM_W  output columns per row
- out_height  in  DIM_W  output rows
- channel  in  DIM_W  input channels per output pixel
- busy  out  1  high in every state except IDLE
- pass_done  out  1  one-cycle pulse when the pass completes
- load_start  out  1  one-cycle pulse requesting a window load
- load_done  in  1  level; loader clears it on the edge it accepts load_start
- mac_start  out  1  one-cycle pulse requesting one channel's MAC
- mac_first  out  1  qualifies mac_start; high when ch_idx==0 (clear accumulator)
- mac_done  in  1  one-cycle pulse from the MAC array
- wr_valid  out  1  one-cycle pulse; accumulated pixel ready to write
- out_x, out_y  out  DIM_W each  current output column / row
- ch_idx  out  DIM_W  current channel index

## Operation
- States: IDLE, LOAD_REQ, LOAD_WAIT, MAC_REQ, MAC_WAIT, WRITE, FINISH.
- IDLE: if start, latch out_width/out_height/channel into shadow registers and clear out_x/out_y/ch_idx. If any latched dimension is 0, go to FINISH; else go to LOAD_REQ. Dimension inputs are ignored outside IDLE.
- LOAD_REQ: load_start=1 for this cycle only, then go to LOAD_WAIT.
- LOAD_WAIT: sample load_done only here. When it is 1, go to MAC_REQ.
- MAC_REQ: mac_start=1 and mac_first=(ch_idx==0) for this cycle only, then go to MAC_WAIT.
- MAC_WAIT: on mac_done:
  - if ch_idx < channel−1: ch_idx+1, go to LOAD_REQ
  - else: go to WRITE
- WRITE: wr_valid=1 with out_x/out_y of the finished pixel. On exit: ch_idx←0 and out_x+1.
  - When out_x wraps (out_x==out_width−1), out_x←0 and out_y+1.
  - If that pixel was (out_width−1, out_height−1), go to FINISH; else go to LOAD_REQ.
- FINISH: pass_done=1 for one cycle, then go to IDLE.
- Arithmetic: counters are unsigned DIM_W bits. Compare against latched dimension −1 using DIM_W-bit subtraction; this is valid because zero dims are filtered out in IDLE.
- mac_done outside MAC_WAIT and load_done outside LOAD_WAIT are ignored.
- start while busy is ignored; no queuing.
- Reset: state=IDLE. busy, pass_done, load_start, mac_start, mac_first, wr_valid = 0. out_x, out_y, ch_idx and shadow registers = 0.
- rst mid-pass: abort at the next edge with no pass_done; the loader and MAC must be reset together with this block.

## Timing
- start at edge E0 → load_start high in cycle E0..E1, accepted by the loader at E1.
- load_done seen at edge En → mac_start high in the following cycle. Each handshake costs exactly 1 cycle of scheduler overhead.
- Per channel: 2 + load latency + MAC latency cycles, counted from LOAD_REQ entry to the MAC_WAIT exit edge.
- Per pixel: channel × per-channel cycles + 1 (WRITE).
- Last WRITE → pass_done the next cycle → busy low the cycle after.
- All outputs are registered; no combinational path from an input to any output.

## Test plan
- Reset: assert rst for 3 cycles mid-pass → all outputs 0, state IDLE, no pass_done pulse.
- Basic pass: width=2, height=2, channel=3, loader done after 4 cycles, MAC done after 2 → exactly 12 load_start and 12 mac_start. mac_first high on every third mac_start. 4 wr_valid at (0,0),(1,0),(0,1),(1,1). One pass_done.
- Zero dimension: channel=0 with start → pass_done 2 cycles after start. No load_start, mac_start or wr_valid.
- Stale handshakes: load_done held high while in IDLE, stray mac_done during LOAD_WAIT → no premature transition; counts same as the basic pass.
- Start while busy, and inputs changed mid-pass (width 2→5) → ignored; pass finishes with the latched width=2.
- Wrap at maximum: width=4095, height=1, channel=1 → 4095 wr_valid; out_x returns to 0 after the last one; pass_done follows.
